// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bus bundle between the data-memory arbiter, its two
// requesters (CPU load/store path, debug/loader port) and the SRAM.
// The slave modport is the arbiter's view; master is the requester/SRAM side.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic [1:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dbg_req;
  logic [1:0]  dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;

  logic        mem_read;
  logic [1:0]  mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    output dbg_ack, dbg_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    input  dbg_ack, dbg_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory SRAM port between the CPU
// load/store path and the debug/loader port. Accesses are serialised by an
// IDLE -> ISSUE (-> RDATA) sequencer; SRAM controls are driven from registers.
// Optional feature macro: DMEM_ARB_STARVE_EN enables a starvation guard that
// forces a waiting debug request through after STARVE_LIMIT lost arbitrations.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RDATA = 2'd2;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_chk
    $error("dmem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  logic [1:0]  state;
  logic        gnt_dbg;       // owner of the access in flight
  logic [1:0]  acc_we;        // size code of the access in flight
  logic        cpu_ack_q;
  logic        dbg_ack_q;
  logic [31:0] cpu_rdata_q;
  logic [31:0] dbg_rdata_q;
  logic        mem_read_q;
  logic [1:0]  mem_write_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        any_req;
  logic        sel_dbg;
  logic        starve_fire;
  logic [1:0]  sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  assign starve_fire = (starve_cnt >= LIMIT);

  // Count IDLE arbitrations debug loses to the CPU; clear once debug is served or withdraws
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!bus.dbg_req) begin
      starve_cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (sel_dbg) begin
        starve_cnt <= 4'd0;
      end else if (bus.cpu_req && starve_cnt != 4'hF) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`else
  assign starve_fire = 1'b0;
`endif

  // Arbitration: CPU first; debug when the CPU is quiet or the guard fires
  always_comb begin
    any_req   = bus.cpu_req | bus.dbg_req;
    sel_dbg   = bus.dbg_req & (~bus.cpu_req | starve_fire);
    sel_we    = sel_dbg ? bus.dbg_we    : bus.cpu_we;
    sel_addr  = sel_dbg ? bus.dbg_addr  : bus.cpu_addr;
    sel_wdata = sel_dbg ? bus.dbg_wdata : bus.cpu_wdata;
  end

  // Access sequencer: grant and latch in IDLE, command in ISSUE, return load data in RDATA
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt_dbg     <= 1'b0;
      acc_we      <= 2'b00;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= 32'd0;
      dbg_rdata_q <= 32'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 2'b00;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_dbg     <= sel_dbg;
            acc_we      <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_read_q  <= (sel_we == 2'b00);
            mem_write_q <= sel_we;
            // a write completes in the same cycle the SRAM sees the command
            if (sel_we != 2'b00) begin
              cpu_ack_q <= ~sel_dbg;
              dbg_ack_q <= sel_dbg;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 2'b00;
          if (acc_we == 2'b00) begin
            // SRAM read data lands one cycle later, alongside the ack
            cpu_ack_q <= ~gnt_dbg;
            dbg_ack_q <= gnt_dbg;
            state     <= RDATA;
          end else begin
            state <= IDLE;
          end
        end
        RDATA: begin
          if (gnt_dbg) begin
            dbg_rdata_q <= bus.mem_rdata;
          end else begin
            cpu_rdata_q <= bus.mem_rdata;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs: load data passes straight through during RDATA, then holds
  always_comb begin
    bus.cpu_ack   = cpu_ack_q;
    bus.dbg_ack   = dbg_ack_q;
    bus.cpu_rdata = (state == RDATA && !gnt_dbg) ? bus.mem_rdata : cpu_rdata_q;
    bus.dbg_rdata = (state == RDATA &&  gnt_dbg) ? bus.mem_rdata : dbg_rdata_q;
    bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;
    bus.mem_read  = mem_read_q;
    bus.mem_write = mem_write_q;
    bus.mem_addr  = mem_addr_q;
    bus.mem_wdata = mem_wdata_q;
    bus.busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a small behavioural
// SRAM (1-cycle registered read, byte/half/word writes by address lane).
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bit [31:0] sram [0:63];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM
  always_ff @(posedge clk) begin
    if (bus.mem_read) bus.mem_rdata <= sram[bus.mem_addr[7:2]];
    case (bus.mem_write)
      2'b01: sram[bus.mem_addr[7:2]][{bus.mem_addr[1:0], 3'b000} +: 8]  <= bus.mem_wdata[7:0];
      2'b10: sram[bus.mem_addr[7:2]][{bus.mem_addr[1], 4'b0000} +: 16] <= bus.mem_wdata[15:0];
      2'b11: sram[bus.mem_addr[7:2]] <= bus.mem_wdata;
      default: ;
    endcase
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({bus.busy, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata} !== {1'b0, 1'b0, 2'b00, 32'h0, 32'h0})
      $display("FAIL reset_mem got=%h exp=%h", {bus.busy, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata}, {1'b0, 1'b0, 2'b00, 32'h0, 32'h0});
    else pass_cnt++;
    total_cnt++;
    if ({bus.cpu_ack, bus.dbg_ack, bus.cpu_rdata, bus.dbg_rdata, bus.cpu_stall} !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b0})
      $display("FAIL reset_port got=%h exp=%h", {bus.cpu_ack, bus.dbg_ack, bus.cpu_rdata, bus.dbg_rdata, bus.cpu_stall}, {1'b0, 1'b0, 32'h0, 32'h0, 1'b0});
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cpu_write_read();
    // cycle T: word write request
    bus.cpu_req = 1'b1; bus.cpu_we = 2'b11; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'hDEADBEEF;
    #1;
    total_cnt++;
    if (bus.cpu_stall !== 1'b1) $display("FAIL wr_stall_T got=%b exp=1", bus.cpu_stall);
    else pass_cnt++;
    @(negedge clk); // T+1
    total_cnt++;
    if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.cpu_ack, bus.busy, bus.cpu_stall} !== {1'b0, 2'b11, 32'h40, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0})
      $display("FAIL wr_issue got=%h exp=%h", {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.cpu_ack, bus.busy, bus.cpu_stall}, {1'b0, 2'b11, 32'h40, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0});
    else pass_cnt++;
    bus.cpu_req = 1'b0;
    @(negedge clk); // T+2
    total_cnt++;
    if ({bus.busy, bus.cpu_ack, bus.mem_write} !== {1'b0, 1'b0, 2'b00})
      $display("FAIL wr_done got=%h exp=%h", {bus.busy, bus.cpu_ack, bus.mem_write}, {1'b0, 1'b0, 2'b00});
    else pass_cnt++;
    // read back
    bus.cpu_req = 1'b1; bus.cpu_we = 2'b00;
    @(negedge clk);
    total_cnt++;
    if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.cpu_ack, bus.cpu_stall} !== {1'b1, 2'b00, 32'h40, 1'b0, 1'b1})
      $display("FAIL rd_issue got=%h exp=%h", {bus.mem_read, bus.mem_write, bus.mem_addr, bus.cpu_ack, bus.cpu_stall}, {1'b1, 2'b00, 32'h40, 1'b0, 1'b1});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.cpu_ack, bus.cpu_rdata, bus.mem_read, bus.busy} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b1})
      $display("FAIL rd_data got=%h exp=%h", {bus.cpu_ack, bus.cpu_rdata, bus.mem_read, bus.busy}, {1'b1, 32'hDEADBEEF, 1'b0, 1'b1});
    else pass_cnt++;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({bus.busy, bus.cpu_ack, bus.cpu_rdata} !== {1'b0, 1'b0, 32'hDEADBEEF})
      $display("FAIL rd_hold got=%h exp=%h", {bus.busy, bus.cpu_ack, bus.cpu_rdata}, {1'b0, 1'b0, 32'hDEADBEEF});
    else pass_cnt++;
  endtask

  task automatic test_dbg_byte_write();
    bus.dbg_req = 1'b1; bus.dbg_we = 2'b01; bus.dbg_addr = 32'h40; bus.dbg_wdata = 32'h00000055;
    #1;
    total_cnt++;
    if (bus.cpu_stall !== 1'b0) $display("FAIL dbg_stall got=%b exp=0", bus.cpu_stall);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.mem_write, bus.mem_read, bus.mem_addr, bus.dbg_ack, bus.cpu_ack, bus.cpu_stall} !== {2'b01, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0})
      $display("FAIL dbg_issue got=%h exp=%h", {bus.mem_write, bus.mem_read, bus.mem_addr, bus.dbg_ack, bus.cpu_ack, bus.cpu_stall}, {2'b01, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0});
    else pass_cnt++;
    bus.dbg_req = 1'b0;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 2'b00; bus.cpu_addr = 32'h40;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, 32'hDEADBE55})
      $display("FAIL dbg_byte_merge got=%h exp=%h", {bus.cpu_ack, bus.cpu_rdata}, {1'b1, 32'hDEADBE55});
    else pass_cnt++;
    bus.cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    bus.cpu_req = 1'b1; bus.cpu_we = 2'b11; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'h11111111;
    bus.dbg_req = 1'b1; bus.dbg_we = 2'b11; bus.dbg_addr = 32'h20; bus.dbg_wdata = 32'h22222222;
    #1;
    total_cnt++;
    if (bus.cpu_stall !== 1'b1) $display("FAIL sim_stall_T got=%b exp=1", bus.cpu_stall);
    else pass_cnt++;
    @(negedge clk); // T+1: CPU wins
    total_cnt++;
    if ({bus.cpu_ack, bus.dbg_ack, bus.mem_addr, bus.mem_wdata, bus.cpu_stall} !== {1'b1, 1'b0, 32'h10, 32'h11111111, 1'b0})
      $display("FAIL sim_cpu_first got=%h exp=%h", {bus.cpu_ack, bus.dbg_ack, bus.mem_addr, bus.mem_wdata, bus.cpu_stall}, {1'b1, 1'b0, 32'h10, 32'h11111111, 1'b0});
    else pass_cnt++;
    bus.cpu_req = 1'b0;
    @(negedge clk); // T+2: IDLE, debug arbitrated
    total_cnt++;
    if ({bus.dbg_ack, bus.busy, bus.cpu_ack} !== {1'b0, 1'b0, 1'b0})
      $display("FAIL sim_gap got=%h exp=%h", {bus.dbg_ack, bus.busy, bus.cpu_ack}, {1'b0, 1'b0, 1'b0});
    else pass_cnt++;
    @(negedge clk); // T+3: debug write issued
    total_cnt++;
    if ({bus.dbg_ack, bus.mem_write, bus.mem_addr, bus.mem_wdata} !== {1'b1, 2'b11, 32'h20, 32'h22222222})
      $display("FAIL sim_dbg_second got=%h exp=%h", {bus.dbg_ack, bus.mem_write, bus.mem_addr, bus.mem_wdata}, {1'b1, 2'b11, 32'h20, 32'h22222222});
    else pass_cnt++;
    bus.dbg_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_addr_hold();
    bus.cpu_req = 1'b1; bus.cpu_we = 2'b00; bus.cpu_addr = 32'h10;
    @(negedge clk); // ISSUE
    total_cnt++;
    if ({bus.mem_read, bus.mem_addr} !== {1'b1, 32'h10})
      $display("FAIL hold_issue got=%h exp=%h", {bus.mem_read, bus.mem_addr}, {1'b1, 32'h10});
    else pass_cnt++;
    bus.cpu_addr = 32'h20;
    @(negedge clk); // RDATA
    total_cnt++;
    if ({bus.cpu_ack, bus.cpu_rdata, bus.mem_addr} !== {1'b1, 32'h11111111, 32'h10})
      $display("FAIL hold_data got=%h exp=%h", {bus.cpu_ack, bus.cpu_rdata, bus.mem_addr}, {1'b1, 32'h11111111, 32'h10});
    else pass_cnt++;
    bus.cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int cpu_acks = 0;
    int dbg_acks = 0;
    int hit_cyc  = -1;
    logic [31:0] dbg_data = 32'h0;
    bus.cpu_req = 1'b1; bus.cpu_we = 2'b00; bus.cpu_addr = 32'h40;
    bus.dbg_req = 1'b1; bus.dbg_we = 2'b00; bus.dbg_addr = 32'h20;
`ifdef DMEM_ARB_STARVE_EN
    for (int c = 0; c < 40 && hit_cyc < 0; c++) begin
      @(negedge clk);
      if (bus.dbg_ack) begin
        dbg_acks++;
        hit_cyc  = c;
        dbg_data = bus.dbg_rdata;
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
      end else if (bus.cpu_ack) begin
        cpu_acks++;
      end
    end
    total_cnt++;
    if (hit_cyc !== 13) $display("FAIL starve_grant_cycle got=%0d exp=13", hit_cyc);
    else pass_cnt++;
    total_cnt++;
    if (cpu_acks !== 4) $display("FAIL starve_cpu_before got=%0d exp=4", cpu_acks);
    else pass_cnt++;
    total_cnt++;
    if (dbg_data !== 32'h22222222) $display("FAIL starve_dbg_rdata got=%h exp=22222222", dbg_data);
    else pass_cnt++;
`else
    for (int c = 0; c < 40 && hit_cyc < 0; c++) begin
      @(negedge clk);
      if (bus.dbg_ack) dbg_acks++;
      if (bus.cpu_ack) begin
        cpu_acks++;
        if (cpu_acks == 8) begin
          hit_cyc = c;
          bus.cpu_req = 1'b0;
          bus.dbg_req = 1'b0;
        end
      end
    end
    total_cnt++;
    if (hit_cyc !== 22) $display("FAIL strict_cpu8_cycle got=%0d exp=22", hit_cyc);
    else pass_cnt++;
    total_cnt++;
    if (dbg_acks !== 0) $display("FAIL strict_dbg_blocked got=%0d exp=0", dbg_acks);
    else pass_cnt++;
    total_cnt++;
    if (bus.cpu_rdata !== 32'hDEADBE55) $display("FAIL strict_cpu_rdata got=%h exp=deadbe55", bus.cpu_rdata);
    else pass_cnt++;
`endif
    @(negedge clk);
    total_cnt++;
    if ({bus.busy, bus.dbg_ack, bus.cpu_ack} !== 3'b000)
      $display("FAIL starve_idle got=%b exp=000", {bus.busy, bus.dbg_ack, bus.cpu_ack});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bus.cpu_req = 1'b1; bus.cpu_we = 2'b00; bus.cpu_addr = 32'h10;
    @(negedge clk); // ISSUE
    @(negedge clk); // RDATA
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({bus.busy, bus.cpu_ack, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.cpu_rdata} !== {1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0})
      $display("FAIL rstmid_clear got=%h exp=%h", {bus.busy, bus.cpu_ack, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.cpu_rdata}, {1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0});
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({bus.mem_read, bus.mem_addr, bus.cpu_ack} !== {1'b1, 32'h10, 1'b0})
      $display("FAIL rstmid_reissue got=%h exp=%h", {bus.mem_read, bus.mem_addr, bus.cpu_ack}, {1'b1, 32'h10, 1'b0});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, 32'h11111111})
      $display("FAIL rstmid_complete got=%h exp=%h", {bus.cpu_ack, bus.cpu_rdata}, {1'b1, 32'h11111111});
    else pass_cnt++;
    bus.cpu_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 2'b00; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
    bus.dbg_req = 1'b0; bus.dbg_we = 2'b00; bus.dbg_addr = 32'h0; bus.dbg_wdata = 32'h0;
    test_reset();
    test_cpu_write_read();
    test_dbg_byte_write();
    test_simultaneous();
    test_addr_hold();
    test_starvation();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
